// File: rtl/led_matrix_pkg.sv
// Shared types and helpers for the LED matrix PWM driver: scan state encoding,
// the default intensity type and the PWM slot count per row.
package led_matrix_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam int BITS_DEFAULT = 2;

  typedef logic [BITS_DEFAULT-1:0] intensity_t;

  // Number of PWM time slots in one row's DRIVE phase.
  function automatic int slots_per_row(input int bits);
    return (1 << bits) - 1;
  endfunction

endpackage

// File: rtl/led_matrix_pwm_driver_if.sv
// Frame hand-over bus between game logic (master) and the matrix driver (slave).
// Handshake: a frame transfers on a clock edge where frame_valid and frame_ready are both high;
// the master holds frame_valid and the arrays stable until then, and ready never depends on valid.
interface led_matrix_pwm_driver_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int BITS = 2
) ();

  logic [ROWS-1:0][COLS-1:0][BITS-1:0] red_array;
  logic [ROWS-1:0][COLS-1:0][BITS-1:0] green_array;
  logic                                frame_valid;
  logic                                frame_ready;

  modport master (
    output red_array,
    output green_array,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  red_array,
    input  green_array,
    input  frame_valid,
    output frame_ready
  );

endinterface

// File: rtl/led_scan_timer.sv
// Row scan sequencer: per-row BLANK then DRIVE phases, PWM slot and dwell counting,
// row counter with wrap strobe and a registered frame_start pulse.
module led_scan_timer #(
  parameter int  ROWS  = 8,
  parameter int  BITS  = 2,
  parameter int  DWELL = 4,
  parameter int  BLANK = 1,
  localparam int CNTW  = $clog2(ROWS)
) (
  input  logic                        Clock,
  input  logic                        reset,
  output led_matrix_pkg::scan_state_t state_o,
  output logic [BITS-1:0]             slot_o,
  output logic [CNTW-1:0]             count_o,
  output logic                        drive_o,
  output logic                        row_wrap_o,
  output logic                        frame_start_o
);
  import led_matrix_pkg::*;

  localparam int S    = slots_per_row(BITS);
  localparam int DMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int DW   = $clog2(DMAX + 1);
  localparam scan_state_t ROW_FIRST = (BLANK > 0) ? led_matrix_pkg::BLANK : DRIVE;

  scan_state_t     state_q, state_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [BITS-1:0] slot_q, slot_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            frame_start_q, frame_start_d;
  logic            blank_done, slot_done, row_done, wrap;

  always_ff @(posedge Clock) begin
    if (reset) begin
      state_q       <= ROW_FIRST;
      dwell_q       <= '0;
      slot_q        <= '0;
      count_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dwell_q       <= dwell_d;
      slot_q        <= slot_d;
      count_q       <= count_d;
      frame_start_q <= frame_start_d;
    end
  end

  // frame_start is registered from the wrap, so it lines up with row 0's first clock.
  always_comb begin
    blank_done    = (state_q == led_matrix_pkg::BLANK) && (dwell_q == DW'(BLANK - 1));
    slot_done     = (state_q == DRIVE) && (dwell_q == DW'(DWELL - 1));
    row_done      = slot_done && (slot_q == BITS'(S - 1));
    wrap          = row_done && (count_q == CNTW'(ROWS - 1));
    state_d       = state_q;
    dwell_d       = dwell_q + DW'(1);
    slot_d        = slot_q;
    count_d       = count_q;
    frame_start_d = wrap;
    if (blank_done) begin
      state_d = DRIVE;
      dwell_d = '0;
      slot_d  = '0;
    end else if (row_done) begin
      state_d = ROW_FIRST;
      dwell_d = '0;
      slot_d  = '0;
      count_d = wrap ? '0 : count_q + CNTW'(1);
    end else if (slot_done) begin
      dwell_d = '0;
      slot_d  = slot_q + BITS'(1);
    end
  end

  always_comb begin
    state_o       = state_q;
    slot_o        = slot_q;
    count_o       = count_q;
    drive_o       = (state_q == DRIVE);
    row_wrap_o    = wrap;
    frame_start_o = frame_start_q;
  end

endmodule

// File: rtl/led_matrix_pwm_driver.sv
// Row-scanning red/green LED matrix driver with time-slot PWM and a double-buffered frame input.
// Optional lamp test behind LED_MATRIX_TEST_PATTERN_EN (adds test_en, forcing full intensity).
module led_matrix_pwm_driver #(
  parameter int  ROWS  = 8,
  parameter int  COLS  = 8,
  parameter int  BITS  = 2,
  parameter int  DWELL = 4,
  parameter int  BLANK = 1,
  localparam int CNTW  = $clog2(ROWS)
) (
  input  logic                        Clock,
  input  logic                        reset,
`ifdef LED_MATRIX_TEST_PATTERN_EN
  input  logic                        test_en,
`endif
  led_matrix_pwm_driver_if.slave      frame_if,
  output logic [COLS-1:0]             red_driver,
  output logic [COLS-1:0]             green_driver,
  output logic [ROWS-1:0]             row_sink,
  output logic [CNTW-1:0]             count,
  output logic                        frame_start,
  output led_matrix_pkg::scan_state_t state_dbg_o
);
  import led_matrix_pkg::*;

  typedef logic [ROWS-1:0][COLS-1:0][BITS-1:0] plane_t;

  plane_t          disp_red_q, disp_green_q, shd_red_q, shd_green_q;
  logic            pending_q;
  logic [BITS-1:0] slot;
  logic            drive, row_wrap;
  logic [BITS-1:0] pix_red, pix_green;

  led_scan_timer #(
    .ROWS (ROWS),
    .BITS (BITS),
    .DWELL(DWELL),
    .BLANK(BLANK)
  ) u_timer (
    .Clock        (Clock),
    .reset        (reset),
    .state_o      (state_dbg_o),
    .slot_o       (slot),
    .count_o      (count),
    .drive_o      (drive),
    .row_wrap_o   (row_wrap),
    .frame_start_o(frame_start)
  );

  // Ready is low while a frame waits in the shadow, so a load and a swap never share an edge.
  always_ff @(posedge Clock) begin
    if (reset) begin
      disp_red_q   <= '0;
      disp_green_q <= '0;
      shd_red_q    <= '0;
      shd_green_q  <= '0;
      pending_q    <= 1'b0;
    end else if (row_wrap && pending_q) begin
      disp_red_q   <= shd_red_q;
      disp_green_q <= shd_green_q;
      pending_q    <= 1'b0;
    end else if (frame_if.frame_valid && !pending_q) begin
      shd_red_q    <= frame_if.red_array;
      shd_green_q  <= frame_if.green_array;
      pending_q    <= 1'b1;
    end
  end

  assign frame_if.frame_ready = !pending_q;

  always_comb begin
    red_driver   = '0;
    green_driver = '0;
    row_sink     = '1;
    pix_red      = '0;
    pix_green    = '0;
    if (drive) begin
      row_sink[count] = 1'b0;
      for (int c = 0; c < COLS; c++) begin
        pix_red   = disp_red_q[count][c];
        pix_green = disp_green_q[count][c];
`ifdef LED_MATRIX_TEST_PATTERN_EN
        if (test_en) begin
          pix_red   = '1;
          pix_green = '1;
        end
`endif
        red_driver[c]   = (pix_red > slot);
        green_driver[c] = (pix_green > slot);
      end
    end
  end

endmodule
